// File: rtl/ic_pkg.sv
// Shared widths, AXI encodings and FSM state type for the I-cache read DMA.
package ic_pkg;
  localparam int IC_ADDR_W     = 33;
  localparam int IC_LINE_W     = 128;
  localparam int IC_LINE_BYTES = 16;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {IDLE, AR, R, ACK, GAP} ic_state_e;
endpackage

// File: rtl/ic_dma_rd_ctrl.sv
// I-cache line-fetch read DMA: one outstanding single-beat AXI4 read per request.
// Define IC_DMA_TIMEOUT_EN to abort stalled AR/R phases after TMO_CYC cycles.
module ic_dma_rd_ctrl
  import ic_pkg::*;
#(
  parameter int ADDR_W  = IC_ADDR_W,
  parameter int DATA_W  = IC_LINE_W,
  parameter int ID_W    = 4,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_read_dma_valid_i,
  input  logic [ADDR_W-1:0] ic_read_dma_addr_i,
  output logic              ic_read_dma_ack_o,
  output logic [ADDR_W-1:0] ic_read_addr_o,
  output logic [DATA_W-1:0] ic_read_data_o,
  output logic              dma_err_o,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [ID_W-1:0]   m_axi_arid,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic [ID_W-1:0]   m_axi_rid
);
  localparam int OFF_W = $clog2(IC_LINE_BYTES);

  ic_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              tmo_hit;
  logic              tmo_abort;
  logic              unused_sig;

`ifdef IC_DMA_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;

  // Held at zero while idle, so every AR entry starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == AR || state_q == R) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit    = (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
  assign unused_sig = ^{m_axi_rlast, m_axi_rid, ic_read_dma_addr_i[OFF_W-1:0]};
`else
  assign tmo_hit    = 1'b0;
  assign unused_sig = ^{m_axi_rlast, m_axi_rid, ic_read_dma_addr_i[OFF_W-1:0],
                        TMO_W'(TMO_CYC)};
`endif

  // A phase that completes on the deadline cycle wins over the abort.
  assign tmo_abort = tmo_hit && ((state_q == AR && !m_axi_arready) ||
                                 (state_q == R  && !m_axi_rvalid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ic_read_dma_valid_i) state_d = AR;
      AR: begin
        if (m_axi_arready)  state_d = R;
        else if (tmo_abort) state_d = ACK;
      end
      R: begin
        if (m_axi_rvalid)   state_d = ACK;
        else if (tmo_abort) state_d = ACK;
      end
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && ic_read_dma_valid_i) begin
        addr_q <= {ic_read_dma_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
      if (state_q == R && m_axi_rvalid) begin
        data_q <= m_axi_rdata;
        if (m_axi_rresp != RESP_OKAY) err_q <= 1'b1;
      end else if (tmo_abort) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  assign m_axi_arvalid     = (state_q == AR);
  assign m_axi_rready      = (state_q == R);
  assign ic_read_dma_ack_o = (state_q == ACK);
  assign m_axi_araddr      = addr_q;
  assign m_axi_arlen       = 8'd0;
  assign m_axi_arsize      = SIZE_16B;
  assign m_axi_arburst     = BURST_INCR;
  assign m_axi_arid        = '0;
  assign ic_read_addr_o    = addr_q;
  assign ic_read_data_o    = data_q;
  assign dma_err_o         = err_q;
endmodule

// File: tb/tb_ic_dma_rd_ctrl.sv
// Self-checking bench for ic_dma_rd_ctrl: directed cases plus randomized traffic
// against a transaction-count model of the request/AR/R/ack sequence.
module tb_ic_dma_rd_ctrl;
  localparam int AW     = 33;
  localparam int DW     = 128;
  localparam int IW     = 4;
  localparam int TB_TMO = 16;
`ifdef IC_DMA_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic [AW-1:0] addr;
  logic          ack;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          err;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [IW-1:0] arid;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [IW-1:0] rid;

  ic_dma_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TMO_W(16), .TMO_CYC(TB_TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_read_dma_valid_i(valid), .ic_read_dma_addr_i(addr),
    .ic_read_dma_ack_o(ack), .ic_read_addr_o(rd_addr), .ic_read_data_o(rd_data),
    .dma_err_o(err),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arid(arid),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rid(rid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [DW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a request is accepted when nothing is outstanding and the cycle is
  // not the one right after an ack; then one AR, one R beat and one ack follow.
  int            k, n_req, n_ar, n_r, n_ack, acc_cyc, last_ack;
  int            hs_cnt = 0, ack_cnt = 0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_err;
  logic          e_arv, e_rr, e_ack, e_idle;

  always @(negedge clk) begin
    if (!rst_n) begin
      k = 0; n_req = 0; n_ar = 0; n_r = 0; n_ack = 0; acc_cyc = 0; last_ack = -10;
      m_addr = '0; m_data = '0; m_err = 1'b0;
    end else begin
      e_arv  = (n_req > n_ar);
      e_rr   = (n_ar > n_r);
      e_ack  = (n_r > n_ack);
      e_idle = (n_req == n_ack) && (k != last_ack + 1);
      check("arvalid", arvalid, e_arv);
      check("rready", rready, e_rr);
      check("ack", ack, e_ack);
      check("araddr", araddr, m_addr);
      check("rd_addr", rd_addr, m_addr);
      check("rd_data", rd_data, m_data);
      check("dma_err", err, m_err);
      check("ar_static", {arlen, arsize, arburst, arid}, {8'd0, 3'b100, 2'b01, 4'd0});
      if (arvalid && arready) hs_cnt++;
      if (ack) ack_cnt++;
      if (e_ack) begin
        n_ack++;
        last_ack = k;
      end
      if (e_arv && arready) begin
        n_ar++;
      end else if (e_rr && rvalid) begin
        m_data = rdata;
        if (rresp != 2'b00) m_err = 1'b1;
        n_r++;
      end else if (TMO_EN && (e_arv || e_rr) && (k - acc_cyc == TB_TMO)) begin
        m_data = '0;
        m_err  = 1'b1;
        n_ar   = n_req;
        n_r    = n_req;
      end
      if (e_idle && valid) begin
        m_addr = {addr[AW-1:4], 4'h0};
        n_req++;
        acc_cyc = k;
      end
      k++;
    end
  end

  // One full directed transaction; starts and ends just after a rising edge.
  task automatic xact(input logic [AW-1:0] a, input int ar_wait, input int r_wait,
                      input logic [DW-1:0] d, input logic [1:0] resp,
                      input logic [AW-1:0] exp_a, input logic exp_err, input string tag);
    valid = 1'b1; addr = a; arready = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    tick();
    for (int i = 0; i <= ar_wait; i++) begin
      arready = (i == ar_wait);
      rvalid  = 1'b1;
      rdata   = rand_line();
      rresp   = 2'b10;
      if (i > 0) addr = rand_addr();
      @(negedge clk);
      check({tag, " arvalid"}, arvalid, 1'b1);
      check({tag, " araddr"}, araddr, exp_a);
      tick();
    end
    arready = 1'b0;
    for (int j = 0; j <= r_wait; j++) begin
      rvalid = (j == r_wait);
      rdata  = (j == r_wait) ? d : rand_line();
      rresp  = (j == r_wait) ? resp : 2'b11;
      @(negedge clk);
      check({tag, " rready"}, rready, 1'b1);
      tick();
    end
    rvalid = 1'b0; rdata = rand_line(); rresp = 2'b00;
    @(negedge clk);
    check({tag, " ack"}, ack, 1'b1);
    check({tag, " data"}, rd_data, d);
    check({tag, " addr"}, rd_addr, exp_a);
    check({tag, " err"}, err, exp_err);
    tick();
    @(negedge clk);
    check({tag, " gap ack"}, ack, 1'b0);
    check({tag, " gap data"}, rd_data, d);
    check({tag, " gap arvalid"}, arvalid, 1'b0);
    tick();
  endtask

  task automatic idle_cyc(input logic [DW-1:0] d, input string tag);
    valid = 1'b0;
    @(negedge clk);
    check({tag, " held data"}, rd_data, d);
    check({tag, " idle arvalid"}, arvalid, 1'b0);
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ack"}, ack, 1'b0);
    check({tag, " arvalid"}, arvalid, 1'b0);
    check({tag, " rready"}, rready, 1'b0);
    check({tag, " rd_addr"}, rd_addr, '0);
    check({tag, " rd_data"}, rd_data, '0);
    check({tag, " err"}, err, 1'b0);
  endtask

  task automatic rand_phase(input int ncyc);
    bit saw_ack;
    bit drop_next;
    drop_next = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      saw_ack = ack;
      tick();
      if (drop_next) begin
        valid = 1'b0;
        drop_next = 1'b0;
      end else if (saw_ack) begin
        drop_next = 1'b1;
      end
      if (!valid && $urandom_range(0, 2) == 0) begin
        valid = 1'b1;
        addr  = rand_addr();
      end else if (valid && !drop_next && $urandom_range(0, 3) == 0) begin
        addr = rand_addr();
      end
      arready = ($urandom_range(0, 2) == 0);
      rvalid  = ($urandom_range(0, 2) == 0);
      rdata   = rand_line();
      rresp   = ($urandom_range(0, 63) == 0) ? 2'b10 : 2'b00;
      rlast   = 1'($urandom_range(0, 1));
      rid     = IW'($urandom_range(0, 15));
    end
  endtask

  int h0, a0;

  initial begin
    rst_n = 1'b0; valid = 1'b0; addr = '0; arready = 1'b0; rvalid = 1'b0;
    rdata = '0; rresp = 2'b00; rlast = 1'b1; rid = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("post_reset");
    tick();

    xact(33'h0_0000_0010, 0, 1, {16{8'hA5}}, 2'b00, 33'h10, 1'b0, "t1");
    idle_cyc({16{8'hA5}}, "t1");

    xact(33'h0_0000_123C, 0, 0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2'b00,
         33'h1230, 1'b0, "t2");
    idle_cyc(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, "t2");

    h0 = hs_cnt; a0 = ack_cnt;
    xact(33'h1_8000_0047, 0, 0, {4{32'hDEAD_BEEF}}, 2'b00, 33'h1_8000_0040, 1'b0, "t3a");
    xact(33'h0_4000_00F1, 1, 2, {4{32'h1357_9BDF}}, 2'b00, 33'h0_4000_00F0, 1'b0, "t3b");
    idle_cyc({4{32'h1357_9BDF}}, "t3");
    check("t3 ar handshakes", 128'(hs_cnt - h0), 128'd2);
    check("t3 acks", 128'(ack_cnt - a0), 128'd2);

    xact(33'h0_0ABC_DEF8, 10, 1, {8{16'h5AA5}}, 2'b00, 33'h0_0ABC_DEF0, 1'b0, "t4");
    idle_cyc({8{16'h5AA5}}, "t4");

    xact(33'h0_0000_2000, 0, 0, {4{32'hBAD0_0001}}, 2'b10, 33'h2000, 1'b1, "t5a");
    idle_cyc({4{32'hBAD0_0001}}, "t5a");
    xact(33'h0_0000_3008, 0, 1, {4{32'h600D_0002}}, 2'b00, 33'h3000, 1'b1, "t5b");
    idle_cyc({4{32'h600D_0002}}, "t5b");

`ifdef IC_DMA_TIMEOUT_EN
    valid = 1'b1; addr = 33'h0_0000_4444; arready = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    tick();
    arready = 1'b1;
    @(negedge clk);
    check("t6 arvalid", arvalid, 1'b1);
    tick();
    arready = 1'b0;
    for (int j = 0; j < TB_TMO - 1; j++) begin
      @(negedge clk);
      check("t6 rready", rready, 1'b1);
      check("t6 no ack", ack, 1'b0);
      tick();
    end
    @(negedge clk);
    check("t6 ack", ack, 1'b1);
    check("t6 data", rd_data, '0);
    check("t6 err", err, 1'b1);
    tick();
    valid = 1'b0;
    @(negedge clk);
    tick();
`endif

    valid = 1'b1; addr = 33'h1_F00D_0048; arready = 1'b1; rvalid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("rst arvalid", arvalid, 1'b1);
    tick();
    arready = 1'b0;
    #2;
    check("rst pre rready", rready, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    valid = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("after_async_rst");
    tick();

    rand_phase(4000);
    valid = 1'b0; arready = 1'b1; rvalid = 1'b1;
    repeat (20) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
